// File: rtl/score_display_sched_if.sv
// Game-logic side of the score display: score/state in, scan pins and busy flag out.
interface score_display_sched_if #(
  parameter int SCORE_W = 11
);
  logic               game_state;
  logic [SCORE_W-1:0] score;
  logic [3:0]         anode_n;
  logic [6:0]         seg_n;
  logic               bcd_busy;

  modport master (output game_state, score, input anode_n, seg_n, bcd_busy);
  modport slave  (input game_state, score, output anode_n, seg_n, bcd_busy);
endinterface

// File: rtl/score_display_sched.sv
// Four-digit seven-segment scheduler: sequential binary-to-BCD conversion,
// digit multiplexing, and the blinking game-over message program.
module score_display_sched #(
  parameter int SCORE_W     = 11,
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_DIV   = 50000000
) (
  input logic                  clk,
  input logic                  rst_n,
  score_display_sched_if.slave bus
);

  localparam int REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int CNT_W = $clog2(SCORE_W + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;

  function automatic logic [15:0] add3(input logic [15:0] v);
    logic [15:0] r;
    r = v;
    for (int i = 0; i < 4; i++) begin
      if (v[4*i +: 4] >= 4'd5) r[4*i +: 4] = v[4*i +: 4] + 4'd3;
      else                     r[4*i +: 4] = v[4*i +: 4];
    end
    return r;
  endfunction

  function automatic logic [6:0] font(input logic [3:0] d);
    logic [6:0] r;
    case (d)
      4'd1:    r = 7'b1001111;
      4'd2:    r = 7'b0010010;
      4'd3:    r = 7'b0000110;
      4'd4:    r = 7'b1001100;
      4'd5:    r = 7'b0100100;
      4'd6:    r = 7'b0100000;
      4'd7:    r = 7'b0001111;
      4'd8:    r = 7'b0000000;
      4'd9:    r = 7'b0000100;
      default: r = 7'b0000001;
    endcase
    return r;
  endfunction

  function automatic logic [6:0] msg_font(input logic [3:0] step, input logic [1:0] idx,
                                          input logic [6:0] score_seg);
    logic [6:0] r;
    case (step)
      4'd0: begin
        case (idx)
          2'd0:    r = 7'b1111111;
          2'd1:    r = 7'b1000100;
          2'd2:    r = 7'b0000001;
          default: r = 7'b1000001;
        endcase
      end
      4'd2: begin
        case (idx)
          2'd0:    r = 7'b1110001;
          2'd1:    r = 7'b0000001;
          2'd2:    r = 7'b0100100;
          default: r = 7'b0110000;
        endcase
      end
      4'd1, 4'd3, 4'd7: r = 7'b1111111;
      default:          r = score_seg;
    endcase
    return r;
  endfunction

  logic [1:0]         state_r;
  logic [SCORE_W-1:0] shadow_r;
  logic [SCORE_W-1:0] shift_r;
  logic [15:0]        work_r;
  logic [15:0]        bcd_r;
  logic [CNT_W-1:0]   bit_cnt_r;
  logic               busy_r;
  logic [REF_W-1:0]   ref_cnt_r;
  logic [1:0]         digit_idx_r;
  logic [BLK_W-1:0]   blink_cnt_r;
  logic [3:0]         step_r;
  logic [3:0]         anode_r;
  logic [6:0]         seg_r;

  logic [15:0] adj_s;
  logic [15:0] shifted_s;
  logic        ref_tick_s;
  logic        blink_tick_s;
  logic [3:0]  digit_s;
  logic [3:0]  anode_next_s;
  logic [6:0]  seg_next_s;

  assign adj_s        = add3(work_r);
  assign shifted_s    = (adj_s << 1) | {15'd0, shift_r[SCORE_W-1]};
  assign ref_tick_s   = (ref_cnt_r == REF_W'(REFRESH_DIV - 1));
  assign blink_tick_s = (blink_cnt_r == BLK_W'(BLINK_DIV - 1));

  // Double-dabble engine; the display copy only changes on the final shift
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      shadow_r  <= '0;
      shift_r   <= '0;
      work_r    <= 16'd0;
      bcd_r     <= 16'd0;
      bit_cnt_r <= '0;
      busy_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.score != shadow_r) begin
            state_r <= LOAD;
            busy_r  <= 1'b1;
          end
        end
        LOAD: begin
          shift_r   <= bus.score;
          shadow_r  <= bus.score;
          work_r    <= 16'd0;
          bit_cnt_r <= '0;
          state_r   <= SHIFT;
        end
        SHIFT: begin
          work_r    <= shifted_s;
          shift_r   <= shift_r << 1;
          bit_cnt_r <= bit_cnt_r + CNT_W'(1);
          if (bit_cnt_r == CNT_W'(SCORE_W - 1)) begin
            bcd_r   <= shifted_s;
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  // Refresh prescaler and digit scan index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_cnt_r   <= '0;
      digit_idx_r <= 2'd0;
    end else if (ref_tick_s) begin
      ref_cnt_r   <= '0;
      digit_idx_r <= digit_idx_r + 2'd1;
    end else begin
      ref_cnt_r   <= ref_cnt_r + REF_W'(1);
    end
  end

  // Message program sequencer, parked at step 0 while playing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt_r <= '0;
      step_r      <= 4'd0;
    end else if (bus.game_state) begin
      blink_cnt_r <= '0;
      step_r      <= 4'd0;
    end else if (blink_tick_s) begin
      blink_cnt_r <= '0;
      step_r      <= (step_r == 4'd8) ? 4'd0 : step_r + 4'd1;
    end else begin
      blink_cnt_r <= blink_cnt_r + BLK_W'(1);
    end
  end

  // Select the digit, anode and glyph for the current scan slot
  always_comb begin
    digit_s      = 4'd0;
    anode_next_s = 4'b1111;
    case (digit_idx_r)
      2'd0:    begin digit_s = bcd_r[15:12]; anode_next_s = 4'b0111; end
      2'd1:    begin digit_s = bcd_r[11:8];  anode_next_s = 4'b1011; end
      2'd2:    begin digit_s = bcd_r[7:4];   anode_next_s = 4'b1101; end
      default: begin digit_s = bcd_r[3:0];   anode_next_s = 4'b1110; end
    endcase
    if (bus.game_state) seg_next_s = font(digit_s);
    else                seg_next_s = msg_font(step_r, digit_idx_r, font(digit_s));
  end

  // Anodes and cathodes share one register stage so they switch on the same edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      anode_r <= 4'b1111;
      seg_r   <= 7'b1111111;
    end else begin
      anode_r <= anode_next_s;
      seg_r   <= seg_next_s;
    end
  end

  assign bus.anode_n  = anode_r;
  assign bus.seg_n    = seg_r;
  assign bus.bcd_busy = busy_r;

endmodule

// File: tb/tb_score_display_sched.sv
// Bench for score_display_sched: cycle model of scan, conversion and message program,
// plus literal glyph sweeps for the directed scenarios.
module tb_score_display_sched;
  localparam int SW = 11;
  localparam int RD = 4;
  localparam int BD = 16;

  localparam logic [6:0] FONT [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                       7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                       7'b0000000, 7'b0000100};
  localparam logic [6:0] YOU_T  [4] = '{7'b1111111, 7'b1000100, 7'b0000001, 7'b1000001};
  localparam logic [6:0] LOSE_T [4] = '{7'b1110001, 7'b0000001, 7'b0100100, 7'b0110000};
  localparam logic [3:0] AN_T   [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
  localparam logic [6:0] BLANK  = 7'b1111111;
  localparam logic [6:0] S0 = 7'b0000001, S1 = 7'b1001111, S2 = 7'b0010010, S3 = 7'b0000110;
  localparam logic [6:0] S4 = 7'b1001100, S5 = 7'b0100100, S6 = 7'b0100000, S7 = 7'b0001111;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int n_checks = 0;
  int n_fail = 0;

  score_display_sched_if #(.SCORE_W(SW)) bus();

  score_display_sched #(.SCORE_W(SW), .REFRESH_DIV(RD), .BLINK_DIV(BD)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] dig_seg(input int v, input int idx);
    int d;
    case (idx)
      0:       d = v / 1000;
      1:       d = v / 100;
      2:       d = v / 10;
      default: d = v;
    endcase
    return FONT[d % 10];
  endfunction

  // Model state: expected outputs after the most recent rising edge
  logic [3:0] exp_an = 4'b1111;
  logic [6:0] exp_seg = 7'b1111111;
  logic       exp_busy = 1'b0;

  initial begin
    int ref_edges, g_edges, shadow, busy_left, cap, disp, idx, step;
    bit load_pend;
    ref_edges = 0; g_edges = 0; shadow = 0; busy_left = 0; cap = 0; disp = 0; load_pend = 0;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        ref_edges = 0; g_edges = 0; shadow = 0; busy_left = 0; cap = 0; disp = 0; load_pend = 0;
        exp_an = 4'b1111; exp_seg = 7'b1111111; exp_busy = 1'b0;
      end else begin
        idx = (ref_edges / RD) % 4;
        ref_edges++;
        exp_an = AN_T[idx];
        if (bus.game_state) begin
          exp_seg = dig_seg(disp, idx);
          g_edges = 0;
        end else begin
          step = (g_edges / BD) % 9;
          g_edges++;
          case (step)
            0:         exp_seg = YOU_T[idx];
            2:         exp_seg = LOSE_T[idx];
            1, 3, 7:   exp_seg = BLANK;
            default:   exp_seg = dig_seg(disp, idx);
          endcase
        end
        if (busy_left == 0) begin
          if (int'(bus.score) != shadow) begin
            busy_left = SW + 1;
            load_pend = 1;
          end
        end else begin
          if (load_pend) begin
            cap = int'(bus.score);
            shadow = cap;
            load_pend = 0;
          end
          busy_left--;
          if (busy_left == 0) disp = cap;
        end
        exp_busy = (busy_left != 0);
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_anode", 16'(bus.anode_n), 16'(4'b1111));
        chk("rst_seg", 16'(bus.seg_n), 16'(7'b1111111));
        chk("rst_busy", 16'(bus.bcd_busy), 16'(1'b0));
      end else begin
        chk("anode", 16'(bus.anode_n), 16'(exp_an));
        chk("seg", 16'(bus.seg_n), 16'(exp_seg));
        chk("busy", 16'(bus.bcd_busy), 16'(exp_busy));
      end
    end
  end

  task automatic sweep(input int n, input string nm, input logic [6:0] s0, input logic [6:0] s1,
                       input logic [6:0] s2, input logic [6:0] s3);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      case (bus.anode_n)
        4'b0111: chk({nm, "_d0"}, 16'(bus.seg_n), 16'(s0));
        4'b1011: chk({nm, "_d1"}, 16'(bus.seg_n), 16'(s1));
        4'b1101: chk({nm, "_d2"}, 16'(bus.seg_n), 16'(s2));
        4'b1110: chk({nm, "_d3"}, 16'(bus.seg_n), 16'(s3));
        default: chk({nm, "_anode"}, 16'(bus.anode_n), 16'(4'b0111));
      endcase
    end
  endtask

  initial begin
    int busy_cycles;
    bus.game_state = 1'b1;
    bus.score = '0;
    #1 rst_n = 1'b0;
    #1;
    chk("por_anode", 16'(bus.anode_n), 16'(4'b1111));
    chk("por_seg", 16'(bus.seg_n), 16'(7'b1111111));
    chk("por_busy", 16'(bus.bcd_busy), 16'(1'b0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bus.score = 11'd1234;
    busy_cycles = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (bus.bcd_busy) busy_cycles++;
    end
    chk("busy_len", 16'(busy_cycles), 16'd12);
    sweep(16, "s1234", S1, S2, S3, S4);

    bus.score = 11'd2047;
    repeat (14) @(negedge clk);
    sweep(16, "s2047", S2, S0, S4, S7);
    bus.score = 11'd0;
    repeat (14) @(negedge clk);
    sweep(16, "s0000", S0, S0, S0, S0);

    bus.score = 11'd5;
    repeat (2) @(negedge clk);
    bus.score = 11'd6;
    repeat (12) @(negedge clk);
    sweep(12, "s0005", S0, S0, S0, S5);
    sweep(8, "s0006", S0, S0, S0, S6);

    bus.score = 11'd42;
    repeat (14) @(negedge clk);
    bus.game_state = 1'b0;
    sweep(BD, "you", YOU_T[0], YOU_T[1], YOU_T[2], YOU_T[3]);
    sweep(BD, "blank1", BLANK, BLANK, BLANK, BLANK);
    sweep(BD, "lose", LOSE_T[0], LOSE_T[1], LOSE_T[2], LOSE_T[3]);
    sweep(BD, "blank3", BLANK, BLANK, BLANK, BLANK);
    sweep(3 * BD, "s42a", S0, S0, S4, S2);
    sweep(BD, "blank7", BLANK, BLANK, BLANK, BLANK);
    sweep(BD, "s42b", S0, S0, S4, S2);
    sweep(BD, "you2", YOU_T[0], YOU_T[1], YOU_T[2], YOU_T[3]);
    repeat (8 * BD + 40 - BD) @(negedge clk);
    bus.game_state = 1'b1;
    sweep(8, "resume", S0, S0, S4, S2);
    bus.game_state = 1'b0;
    sweep(BD, "you3", YOU_T[0], YOU_T[1], YOU_T[2], YOU_T[3]);
    sweep(BD, "blank1b", BLANK, BLANK, BLANK, BLANK);

    bus.game_state = 1'b1;
    repeat (5) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_anode", 16'(bus.anode_n), 16'(4'b1111));
    chk("async_seg", 16'(bus.seg_n), 16'(7'b1111111));
    chk("async_busy", 16'(bus.bcd_busy), 16'(1'b0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("restart_anode", 16'(bus.anode_n), 16'(4'b0111));
    repeat (40) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
